// File: rtl/uart_rx.sv
// uart_rx: 8N1-style UART receiver driven by a 16x (OVERSAMPLE) tick strobe.
// Start bit is validated at its midpoint, data/stop bits are sampled mid-bit,
// and each good byte lands in a single-entry valid/ready holding register.
module uart_rx #(
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tick_os,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int OS_W = $clog2(OVERSAMPLE);
    localparam int BC_W = $clog2(DATA_BITS + 1);
    localparam logic [OS_W-1:0] OS_HALF = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_BITS - 1);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_rx: DATA_BITS must be in 5..9");
    end
    if (OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0) begin : g_bad_oversample
        $error("uart_rx: OVERSAMPLE must be even and >= 4");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("uart_rx: SYNC_STAGES must be >= 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t                 state, state_d;
    logic [OS_W-1:0]        os_cnt, os_d;
    logic [BC_W-1:0]        bit_cnt, bit_d;
    logic [DATA_BITS-1:0]   shreg, shreg_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    logic                   stop_tick;
    logic                   deliver;
    logic                   load;
    logic                   fe_set;
    logic                   ov_set;

    assign rx_s = sync_q[SYNC_STAGES-1];

    // Metastability synchroniser for the asynchronous rx line (idles high).
    always_ff @(posedge clk) begin
        if (!rst_n) sync_q <= '1;
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
    end

    // State register: FSM state, oversample/bit counters and shift register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            os_cnt  <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_d;
            os_cnt  <= os_d;
            bit_cnt <= bit_d;
            shreg   <= shreg_d;
        end
    end

    // Next-state logic; everything advances only on tick_os cycles.
    always_comb begin
        state_d = state;
        os_d    = os_cnt;
        bit_d   = bit_cnt;
        shreg_d = shreg;
        if (tick_os) begin
            unique case (state)
                S_IDLE: begin
                    os_d = '0;
                    if (!rx_s) state_d = S_START;
                end
                S_START: begin
                    if (os_cnt == OS_HALF) begin
                        os_d    = '0;
                        bit_d   = '0;
                        state_d = rx_s ? S_IDLE : S_DATA;
                    end else begin
                        os_d = os_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (os_cnt == OS_LAST) begin
                        shreg_d = {rx_s, shreg[DATA_BITS-1:1]};
                        os_d    = '0;
                        bit_d   = bit_cnt + 1'b1;
                        if (bit_cnt == BC_LAST) state_d = S_STOP;
                    end else begin
                        os_d = os_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (os_cnt == OS_LAST) begin
                        os_d    = '0;
                        state_d = rx_s ? S_IDLE : S_BREAK;
                    end else begin
                        os_d = os_cnt + 1'b1;
                    end
                end
                S_BREAK: begin
                    if (rx_s) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Output decode: stop-bit outcome and holding-register load/drop decision.
    always_comb begin
        stop_tick = tick_os && (state == S_STOP) && (os_cnt == OS_LAST);
        deliver   = stop_tick && rx_s;
        fe_set    = stop_tick && !rx_s;
        load      = deliver && (!rx_valid || rx_ready);
        ov_set    = deliver && rx_valid && !rx_ready;
    end

    // Registered outputs: holding register, status pulses and busy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            frame_err <= fe_set;
            overrun   <= ov_set;
            // decoded from state_d so busy lines up with the state register
            busy      <= (state_d != S_IDLE);
            if (load) begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx (DATA_BITS=8, OVERSAMPLE=16).
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick_os = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b1;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int tick_div = 1;
    int phase = 0;
    int valid_cycles = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    logic [7:0] sb[$];

    typedef struct {
        logic [7:0] data;
        int         div;
    } vec_t;
    vec_t vecs[5];

    uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick_os   (tick_os),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock; inputs change 1ns after the active edge.
    task automatic cyc();
        @(posedge clk);
        #1;
        tick_os = (phase == 0);
        phase = (phase + 1 >= tick_div) ? 0 : phase + 1;
    endtask

    task automatic do_tick();
        do cyc(); while (!tick_os);
    endtask

    task automatic hold(input logic v, input int n);
        rx = v;
        for (int i = 0; i < n; i++) do_tick();
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        hold(1'b0, 16);
        for (int i = 0; i < 8; i++) hold(d[i], 16);
        hold(stop, 16);
    endtask

    // Output monitor / scoreboard: every accepted byte is compared to the queue head.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid) valid_cycles++;
            if (frame_err) fe_cnt++;
            if (overrun) ov_cnt++;
            if (frame_err || overrun) begin
                checks++;
                if (frame_err && overrun) begin
                    errors++;
                    $display("FAIL flags_exclusive: frame_err=%0b overrun=%0b, expected not both", frame_err, overrun);
                end
            end
            if (rx_valid && rx_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_byte: got 0x%0h, expected no delivery", rx_data);
                end else begin
                    automatic logic [7:0] exp = sb.pop_front();
                    if (rx_data !== exp) begin
                        errors++;
                        $display("FAIL byte: got 0x%0h, expected 0x%0h", rx_data, exp);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        int v0, fe0, ov0, busy_low;
        vecs[0] = '{data: 8'h55, div: 1};
        vecs[1] = '{data: 8'hA3, div: 1};
        vecs[2] = '{data: 8'h00, div: 2};
        vecs[3] = '{data: 8'hFF, div: 1};
        vecs[4] = '{data: 8'h55, div: 3};

        // Reset state
        rst_n = 1'b0;
        repeat (3) cyc();
        check("reset_rx_data", rx_data, 0);
        check("reset_rx_valid", rx_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_frame_err", frame_err, 0);
        check("reset_overrun", overrun, 0);
        rst_n = 1'b1;
        hold(1'b1, 20);

        // Table of clean frames, rx_ready=1, various tick rates
        for (int i = 0; i < 5; i++) begin
            tick_div = vecs[i].div;
            phase = 0;
            v0 = valid_cycles; fe0 = fe_cnt; ov0 = ov_cnt;
            sb.push_back(vecs[i].data);
            send_frame(vecs[i].data, 1'b1);
            hold(1'b1, 16);
            check($sformatf("vec%0d_valid_cycles", i), valid_cycles - v0, 1);
            check($sformatf("vec%0d_frame_err", i), fe_cnt - fe0, 0);
            check($sformatf("vec%0d_overrun", i), ov_cnt - ov0, 0);
            check($sformatf("vec%0d_queue_drained", i), sb.size(), 0);
        end
        tick_div = 1;
        phase = 0;

        // Glitch: 4 ticks low is rejected, then a real frame
        v0 = valid_cycles; fe0 = fe_cnt;
        hold(1'b0, 4);
        hold(1'b1, 20);
        check("glitch_busy", busy, 0);
        check("glitch_valid", valid_cycles - v0, 0);
        check("glitch_frame_err", fe_cnt - fe0, 0);
        sb.push_back(8'hA3);
        send_frame(8'hA3, 1'b1);
        hold(1'b1, 16);
        check("after_glitch_valid", valid_cycles - v0, 1);

        // Framing error then held-low break, then recovery
        v0 = valid_cycles; fe0 = fe_cnt;
        send_frame(8'hC4, 1'b0);
        busy_low = 0;
        rx = 1'b0;
        for (int i = 0; i < 40; i++) begin
            do_tick();
            if (!busy) busy_low++;
        end
        check("break_busy_low_ticks", busy_low, 0);
        hold(1'b1, 20);
        check("break_idle_busy", busy, 0);
        check("break_frame_err", fe_cnt - fe0, 1);
        check("break_no_valid", valid_cycles - v0, 0);
        sb.push_back(8'h3C);
        send_frame(8'h3C, 1'b1);
        hold(1'b1, 16);
        check("break_recover_valid", valid_cycles - v0, 1);
        check("break_recover_data", rx_data, 8'h3C);

        // Overrun: consumer stalled across two frames
        rx_ready = 1'b0;
        ov0 = ov_cnt;
        sb.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        hold(1'b1, 16);
        send_frame(8'h22, 1'b1);
        hold(1'b1, 16);
        check("overrun_count", ov_cnt - ov0, 1);
        check("overrun_valid", rx_valid, 1);
        check("overrun_data", rx_data, 8'h11);
        rx_ready = 1'b1;
        cyc();
        check("consume_valid_fell", rx_valid, 0);
        check("consume_data_kept", rx_data, 8'h11);

        // rx_ready rises exactly on the delivery edge of the next byte
        rx_ready = 1'b0;
        ov0 = ov_cnt;
        sb.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        hold(1'b1, 16);
        sb.push_back(8'h22);
        hold(1'b0, 16);
        for (int i = 0; i < 8; i++) hold(8'h22 >> i, 16);
        // rx set 1 edge before the first tick; +2 sync, +8 start ticks, +16/bit:
        // the stop-sample edge is the 11th stop-bit edge
        hold(1'b1, 10);
        rx_ready = 1'b1;
        hold(1'b1, 1);
        check("handoff_valid", rx_valid, 1);
        check("handoff_data", rx_data, 8'h22);
        check("handoff_overrun_now", overrun, 0);
        hold(1'b1, 20);
        check("handoff_overrun_count", ov_cnt - ov0, 0);
        check("handoff_drained", sb.size(), 0);

        // Reset during data bit 3 of 0xF0
        hold(1'b0, 16);
        for (int i = 0; i < 3; i++) hold(8'hF0 >> i, 16);
        hold(1'b0, 8);
        rst_n = 1'b0;
        cyc();
        cyc();
        check("midreset_rx_data", rx_data, 0);
        check("midreset_rx_valid", rx_valid, 0);
        check("midreset_busy", busy, 0);
        check("midreset_frame_err", frame_err, 0);
        check("midreset_overrun", overrun, 0);
        rst_n = 1'b1;
        fe0 = fe_cnt; v0 = valid_cycles;
        hold(1'b1, 20);
        sb.push_back(8'h7E);
        send_frame(8'h7E, 1'b1);
        hold(1'b1, 16);
        check("postreset_frame_err", fe_cnt - fe0, 0);
        check("postreset_valid", valid_cycles - v0, 1);
        check("postreset_data", rx_data, 8'h7E);

        check("final_queue_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
